// File: rtl/decoder_scan.sv
// decoder_scan: SEL_W-to-2^SEL_W one-hot decoder with a registered output.
// Besides direct decode it holds an index that can step up, step down or
// sweep once, with each position held for DWELL cycles.
module decoder_scan #(
  parameter  int SEL_W = 5,
  parameter  int DWELL = 4,
  parameter  int CNT_W = 16,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] a,
  input  logic             load,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             wrap,
  output logic             done
);

  typedef enum logic [1:0] {
    M_DIRECT = 2'b00,
    M_UP     = 2'b01,
    M_DOWN   = 2'b10,
    M_SWEEP  = 2'b11
  } mode_e;

  if (DWELL < 1 || DWELL > 2**CNT_W) begin : g_bad_dwell
    $error("decoder_scan: DWELL must lie in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
  localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);

  mode_e            mode_q, mode_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] idx_n;
  logic             wrap_n, done_n;
  logic [OUT_W-1:0] y_n;

  // Next-state: mode change > direct decode > load > dwell/step; all frozen while en=0.
  // A mode change edge only restarts the dwell and clears done; idx is kept.
  always_comb begin
    mode_n = mode_q;
    idx_n  = idx;
    cnt_n  = cnt;
    done_n = done;
    wrap_n = 1'b0;
    if (en) begin
      if (mode_e'(mode) != mode_q) begin
        mode_n = mode_e'(mode);
        cnt_n  = '0;
        done_n = 1'b0;
      end else if (mode_q == M_DIRECT) begin
        idx_n  = a;
        cnt_n  = '0;
        done_n = 1'b0;
      end else if (load) begin
        idx_n  = a;
        cnt_n  = '0;
        done_n = 1'b0;
      end else if (!(mode_q == M_SWEEP && done)) begin
        if (cnt == DWELL_M1) begin
          cnt_n = '0;
          case (mode_q)
            M_UP: begin
              wrap_n = (idx == '1);
              idx_n  = idx + SEL_W'(1);
            end
            M_DOWN: begin
              wrap_n = (idx == '0);
              idx_n  = idx - SEL_W'(1);
            end
            M_SWEEP: begin
              if (idx == '1) done_n = 1'b1;
              else           idx_n  = idx + SEL_W'(1);
            end
            default: cnt_n = '0;
          endcase
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    end
    y_n = en ? (ONE << idx_n) : '0;
  end

  // State and output registers; synchronous reset dominates.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_DIRECT;
      idx    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      wrap   <= 1'b0;
      y      <= '0;
    end else begin
      mode_q <= mode_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      done   <= done_n;
      wrap   <= wrap_n;
      y      <= y_n;
    end
  end

endmodule
